apa102_frame_decoder: RTL and testbench

Receive-side decoder for the APA102 LED serial protocol that the strand drivers transmit. It passively samples an `sck`/`mosi` pair in the `clk` domain and reassembles the 32-bit start, LED and end frames. For each LED frame it emits a decoded brightness/BGR strobe, and it reports frame completion and protocol errors. It sits on the loopback test header beside the strand outputs, where it checks lantern and rain patterns in hardware and feeds the verification scoreboard in simulation.

---
 rtl/apa102_pkg.sv | 28 ++
 rtl/apa102_frame_decoder_sync_edge_detect.sv | 31 +++
 rtl/apa102_frame_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_apa102_frame_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apa102_pkg.sv
// Shared APA102 protocol definitions used by the strand drivers and the
// loopback frame decoder.
package apa102_pkg;

   localparam logic [31:0] START_WORD = 32'h0000_0000;
   localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
   localparam logic [2:0]  LED_HDR    = 3'b111;
   localparam logic [31:0] OFF_LED    = 32'hE000_0000;

   typedef struct packed {
      logic [2:0] hdr;
      logic [4:0] bright;
      logic [7:0] blue;
      logic [7:0] green;
      logic [7:0] red;
   } led_word_t;

   typedef enum logic {
      HUNT = 1'b0,
      WORD = 1'b1
   } state_t;

   // OFF_LED is exactly the header mask, so masking with it isolates the header bits.
   function automatic logic is_led_word(input logic [31:0] w);
      return ((w & OFF_LED) == {LED_HDR, 29'h0000_0000}) && (w != END_WORD);
   endfunction

endpackage

// File: rtl/apa102_frame_decoder_sync_edge_detect.sv
// Two-flop synchronizer with a registered previous value, giving the
// synchronized level and single-cycle rise/fall flags in the clk domain.
module sync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic sync_q,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic prev_q;

   // Synchronizer chain plus one delayed copy for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/apa102_frame_decoder.sv
// Passive APA102 receive-side decoder: samples sck/mosi in the clk domain,
// reassembles 32-bit words and reports LED frames, frame end and errors.
module apa102_frame_decoder
   import apa102_pkg::*;
#(
   parameter int  MAX_LEDS       = 16,
   parameter int  TIMEOUT_CYC    = 1024,
   parameter int  SAMPLE_ON_FALL = 1,
   localparam int IDXW           = $clog2(MAX_LEDS + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            sck,
   input  logic            mosi,
   output logic            led_valid,
   output logic [IDXW-1:0] led_index,
   output logic [4:0]      led_bright,
   output logic [7:0]      led_blue,
   output logic [7:0]      led_green,
   output logic [7:0]      led_red,
   output logic            frame_done,
   output logic [IDXW-1:0] frame_len,
   output logic            frame_error,
   output logic            busy
);

   localparam int TMOW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TIMEOUT_CYC - 1);
   localparam logic [IDXW-1:0] IDX_FULL = IDXW'(MAX_LEDS);

   logic sck_rise_s, sck_fall_s, unused_sck_sync_s;
   logic mosi_s, unused_mosi_rise_s, unused_mosi_fall_s;
   logic sample_s;

   sync_edge_detect u_sck_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (sck),
      .sync_q (unused_sck_sync_s),
      .rise   (sck_rise_s),
      .fall   (sck_fall_s)
   );

   sync_edge_detect u_mosi_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (mosi),
      .sync_q (mosi_s),
      .rise   (unused_mosi_rise_s),
      .fall   (unused_mosi_fall_s)
   );

   assign sample_s = (SAMPLE_ON_FALL != 0) ? sck_fall_s : sck_rise_s;

   state_t          state_q, state_d;
   logic [31:0]     shreg_q, shreg_d;
   logic [4:0]      bit_cnt_q, bit_cnt_d;
   logic [5:0]      zcnt_q, zcnt_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [TMOW-1:0] tmo_q, tmo_d;
   logic            word_done_q, word_done_d;

   logic            led_valid_q, led_valid_d;
   logic [IDXW-1:0] led_index_q, led_index_d;
   logic [4:0]      led_bright_q, led_bright_d;
   logic [7:0]      led_blue_q, led_blue_d;
   logic [7:0]      led_green_q, led_green_d;
   logic [7:0]      led_red_q, led_red_d;
   logic            frame_done_q, frame_done_d;
   logic [IDXW-1:0] frame_len_q, frame_len_d;
   logic            frame_error_q, frame_error_d;
   logic            busy_q, busy_d;

   led_word_t word_s;
   assign word_s = shreg_q;

   // Next-state logic: bit assembly, hunt for the start frame, word classification
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      zcnt_d        = zcnt_q;
      idx_d         = idx_q;
      tmo_d         = tmo_q;
      word_done_d   = 1'b0;
      led_valid_d   = 1'b0;
      led_index_d   = led_index_q;
      led_bright_d  = led_bright_q;
      led_blue_d    = led_blue_q;
      led_green_d   = led_green_q;
      led_red_d     = led_red_q;
      frame_done_d  = 1'b0;
      frame_len_d   = frame_len_q;
      frame_error_d = 1'b0;

      if (sample_s) begin
         shreg_d = {shreg_q[30:0], mosi_s};
      end else begin
         shreg_d = shreg_q;
      end

      case (state_q)
         HUNT: begin
            tmo_d = '0;
            if (sample_s) begin
               if (mosi_s) begin
                  zcnt_d = 6'd0;
               end else if (zcnt_q >= 6'd31) begin
                  zcnt_d    = 6'd32;
                  state_d   = WORD;
                  bit_cnt_d = 5'd0;
                  idx_d     = '0;
               end else begin
                  zcnt_d = zcnt_q + 6'd1;
               end
            end else begin
               zcnt_d = zcnt_q;
            end
         end
         WORD: begin
            if (word_done_q) begin
               // Classification runs the cycle after the 32nd bit lands
               tmo_d = tmo_q + TMOW'(1);
               if (is_led_word(shreg_q)) begin
                  if (idx_q == IDX_FULL) begin
                     frame_error_d = 1'b1;
                     state_d       = HUNT;
                     zcnt_d        = 6'd0;
                  end else begin
                     led_valid_d  = 1'b1;
                     led_index_d  = idx_q;
                     led_bright_d = word_s.bright;
                     led_blue_d   = word_s.blue;
                     led_green_d  = word_s.green;
                     led_red_d    = word_s.red;
                     idx_d        = idx_q + IDXW'(1);
                  end
               end else if (shreg_q == END_WORD) begin
                  frame_done_d = 1'b1;
                  frame_len_d  = idx_q;
                  state_d      = HUNT;
                  zcnt_d       = 6'd0;
               end else if ((shreg_q == START_WORD) && (idx_q == '0)) begin
                  state_d = WORD;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = HUNT;
                  zcnt_d        = 6'd0;
               end
            end else if (sample_s) begin
               tmo_d       = '0;
               bit_cnt_d   = bit_cnt_q + 5'd1;
               word_done_d = (bit_cnt_q == 5'd31);
            end else if (tmo_q == TMO_LAST) begin
               frame_error_d = 1'b1;
               state_d       = HUNT;
               zcnt_d        = 6'd0;
            end else begin
               tmo_d = tmo_q + TMOW'(1);
            end
         end
         default: begin
            state_d = HUNT;
            zcnt_d  = 6'd0;
         end
      endcase

      busy_d = (state_d != HUNT);
   end

   // State and output registers; reset discards any frame in progress
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= HUNT;
         shreg_q       <= 32'h0000_0000;
         bit_cnt_q     <= 5'd0;
         zcnt_q        <= 6'd0;
         idx_q         <= '0;
         tmo_q         <= '0;
         word_done_q   <= 1'b0;
         led_valid_q   <= 1'b0;
         led_index_q   <= '0;
         led_bright_q  <= 5'd0;
         led_blue_q    <= 8'd0;
         led_green_q   <= 8'd0;
         led_red_q     <= 8'd0;
         frame_done_q  <= 1'b0;
         frame_len_q   <= '0;
         frame_error_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         zcnt_q        <= zcnt_d;
         idx_q         <= idx_d;
         tmo_q         <= tmo_d;
         word_done_q   <= word_done_d;
         led_valid_q   <= led_valid_d;
         led_index_q   <= led_index_d;
         led_bright_q  <= led_bright_d;
         led_blue_q    <= led_blue_d;
         led_green_q   <= led_green_d;
         led_red_q     <= led_red_d;
         frame_done_q  <= frame_done_d;
         frame_len_q   <= frame_len_d;
         frame_error_q <= frame_error_d;
         busy_q        <= busy_d;
      end
   end

   assign led_valid   = led_valid_q;
   assign led_index   = led_index_q;
   assign led_bright  = led_bright_q;
   assign led_blue    = led_blue_q;
   assign led_green   = led_green_q;
   assign led_red     = led_red_q;
   assign frame_done  = frame_done_q;
   assign frame_len   = frame_len_q;
   assign frame_error = frame_error_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_apa102_frame_decoder.sv
// Directed bench: two decoders (MAX_LEDS=16 and MAX_LEDS=2) share one sck/mosi
// line; strobes are captured into per-instance event queues and compared.
module tb_apa102_frame_decoder;
   import apa102_pkg::*;

   logic clk = 1'b0;
   logic reset, sck, mosi;

   logic       a_valid, a_done, a_err, a_busy;
   logic [4:0] a_index, a_len, a_bright;
   logic [7:0] a_blue, a_green, a_red;
   logic       b_valid, b_done, b_err, b_busy;
   logic [1:0] b_index, b_len;
   logic [4:0] b_bright;
   logic [7:0] b_blue, b_green, b_red;

   apa102_frame_decoder dut (
      .clk(clk), .reset(reset), .sck(sck), .mosi(mosi),
      .led_valid(a_valid), .led_index(a_index), .led_bright(a_bright),
      .led_blue(a_blue), .led_green(a_green), .led_red(a_red),
      .frame_done(a_done), .frame_len(a_len), .frame_error(a_err), .busy(a_busy)
   );

   apa102_frame_decoder #(.MAX_LEDS(2)) dut2 (
      .clk(clk), .reset(reset), .sck(sck), .mosi(mosi),
      .led_valid(b_valid), .led_index(b_index), .led_bright(b_bright),
      .led_blue(b_blue), .led_green(b_green), .led_red(b_red),
      .frame_done(b_done), .frame_len(b_len), .frame_error(b_err), .busy(b_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] kind;   // 1 = led, 2 = done, 3 = error
      logic [4:0] idx;
      logic [4:0] len;
      logic [4:0] bright;
      logic [7:0] blue;
      logic [7:0] green;
      logic [7:0] red;
   } ev_t;

   typedef struct {
      logic [31:0] word;
      logic [4:0]  bright;
      logic [7:0]  blue;
      logic [7:0]  green;
      logic [7:0]  red;
   } vec_t;

   ev_t q1[$];
   ev_t q2[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  multi_cnt = 0;

   function automatic ev_t mk_ev(input logic [1:0] kind, input logic [4:0] idx, input logic [4:0] len,
                                 input logic [4:0] br, input logic [7:0] bl, input logic [7:0] gr,
                                 input logic [7:0] rd);
      ev_t e;
      e.kind = kind; e.idx = idx; e.len = len; e.bright = br; e.blue = bl; e.green = gr; e.red = rd;
      return e;
   endfunction

   // Strobe capture for both instances
   always @(negedge clk) begin
      if (a_valid) q1.push_back(mk_ev(2'd1, a_index, 5'd0, a_bright, a_blue, a_green, a_red));
      if (a_done)  q1.push_back(mk_ev(2'd2, 5'd0, a_len, 5'd0, 8'd0, 8'd0, 8'd0));
      if (a_err)   q1.push_back(mk_ev(2'd3, 5'd0, 5'd0, 5'd0, 8'd0, 8'd0, 8'd0));
      if (b_valid) q2.push_back(mk_ev(2'd1, 5'(b_index), 5'd0, b_bright, b_blue, b_green, b_red));
      if (b_done)  q2.push_back(mk_ev(2'd2, 5'd0, 5'(b_len), 5'd0, 8'd0, 8'd0, 8'd0));
      if (b_err)   q2.push_back(mk_ev(2'd3, 5'd0, 5'd0, 5'd0, 8'd0, 8'd0, 8'd0));
      if ((int'(a_valid) + int'(a_done) + int'(a_err)) > 1) multi_cnt++;
      if ((int'(b_valid) + int'(b_done) + int'(b_err)) > 1) multi_cnt++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input int which, input ev_t exp, input string name);
      ev_t got;
      int  sz;
      sz = (which == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got no event expected %0h", name, exp);
      end else begin
         if (which == 1) got = q1.pop_front();
         else            got = q2.pop_front();
         check(name, 64'(got), 64'(exp));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bit: mosi set with the sck rise, sampled on the following fall
   task automatic send_bit(input logic b);
      mosi = b;
      sck  = 1'b1;
      idle(4);
      sck  = 1'b0;
      idle(4);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) send_bit(w[i]);
   endtask

   // Leading 1 clears any partial zero run left in HUNT
   task automatic start_frame();
      send_bit(1'b1);
      for (int i = 0; i < 32; i++) send_bit(1'b0);
   endtask

   vec_t tbl[5];
   logic [31:0] w16;
   int hit1, hit2;

   initial begin
      tbl[0] = '{32'hFF12_3456, 5'h1F, 8'h12, 8'h34, 8'h56};
      tbl[1] = '{32'hEA00_FF01, 5'h0A, 8'h00, 8'hFF, 8'h01};
      tbl[2] = '{32'hE000_0000, 5'h00, 8'h00, 8'h00, 8'h00};
      tbl[3] = '{32'hF1A5_C33C, 5'h11, 8'hA5, 8'hC3, 8'h3C};
      tbl[4] = '{32'hE7FF_FFFF, 5'h07, 8'hFF, 8'hFF, 8'hFF};

      reset = 1'b1; sck = 1'b0; mosi = 1'b0;
      idle(5);
      reset = 1'b0;
      idle(100);
      check("reset_outs_a", {a_valid, a_index, a_bright, a_blue, a_green, a_red, a_done, a_len, a_err, a_busy}, 64'd0);
      check("reset_outs_b", {b_valid, b_index, b_bright, b_blue, b_green, b_red, b_done, b_len, b_err, b_busy}, 64'd0);
      check("reset_no_events", 64'(q1.size() + q2.size()), 64'd0);

      // Basic frame: two LEDs
      start_frame();
      check("busy_after_start", 64'(a_busy), 64'd1);
      send_word(32'hE5FF_8040);
      send_word(OFF_LED);
      send_word(END_WORD);
      idle(4);
      for (int d = 1; d <= 2; d++) begin
         expect_ev(d, mk_ev(2'd1, 5'd0, 5'd0, 5'd5, 8'hFF, 8'h80, 8'h40), "f1_led0");
         expect_ev(d, mk_ev(2'd1, 5'd1, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00), "f1_led1");
         expect_ev(d, mk_ev(2'd2, 5'd0, 5'd2, 5'd0, 8'h00, 8'h00, 8'h00), "f1_done");
      end
      check("f1_busy_idle", 64'({a_busy, b_busy}), 64'd0);
      check("f1_len_hold", 64'(a_len), 64'd2);
      check("f1_index_hold", 64'(a_index), 64'd1);

      // Table frame with an extra start frame; dut2 overflows on the third LED
      start_frame();
      send_word(START_WORD);
      for (int i = 0; i < 5; i++) send_word(tbl[i].word);
      send_word(END_WORD);
      idle(4);
      for (int i = 0; i < 5; i++)
         expect_ev(1, mk_ev(2'd1, 5'(i), 5'd0, tbl[i].bright, tbl[i].blue, tbl[i].green, tbl[i].red), "tbl_led");
      expect_ev(1, mk_ev(2'd2, 5'd0, 5'd5, 5'd0, 8'h00, 8'h00, 8'h00), "tbl_done");
      for (int i = 0; i < 2; i++)
         expect_ev(2, mk_ev(2'd1, 5'(i), 5'd0, tbl[i].bright, tbl[i].blue, tbl[i].green, tbl[i].red), "max2_led");
      expect_ev(2, mk_ev(2'd3, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00), "max2_err");
      check("tbl_no_extra", 64'(q1.size() + q2.size()), 64'd0);

      // Noise: a 31-zero run must not sync
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      for (int i = 0; i < 31; i++) send_bit(1'b0);
      check("noise_31_zero_hunt", 64'({a_busy, b_busy}), 64'd0);
      send_word(32'hE5FF_8041);
      idle(4);
      check("noise_no_events", 64'(q1.size() + q2.size()), 64'd0);
      check("noise_still_hunt", 64'({a_busy, b_busy}), 64'd0);
      for (int i = 0; i < 31; i++) send_bit(1'b0);
      check("zero31_hunt", 64'(a_busy), 64'd0);
      send_bit(1'b0);
      check("zero32_word", 64'({a_busy, b_busy}), 64'd3);
      send_word(END_WORD);
      idle(4);
      expect_ev(1, mk_ev(2'd2, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00), "empty_done_a");
      expect_ev(2, mk_ev(2'd2, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00), "empty_done_b");

      // Malformed word after the start frame
      start_frame();
      send_word(32'h1234_5678);
      idle(4);
      expect_ev(1, mk_ev(2'd3, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00), "bad_word_a");
      expect_ev(2, mk_ev(2'd3, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00), "bad_word_b");
      check("bad_word_busy", 64'({a_busy, b_busy}), 64'd0);

      // Timeout: stall after 16 bits, error expected 1024 cycles after the shift edge
      start_frame();
      w16 = 32'hE5FF_8040;
      for (int i = 31; i > 16; i--) send_bit(w16[i]);
      mosi = w16[16];
      sck  = 1'b1;
      idle(4);
      sck  = 1'b0;
      hit1 = 0; hit2 = 0;
      for (int c = 1; c <= 1100; c++) begin
         @(negedge clk);
         if (a_err && hit1 == 0) hit1 = c;
         if (b_err && hit2 == 0) hit2 = c;
      end
      check("timeout_cycle_a", 64'(hit1), 64'd1027);
      check("timeout_cycle_b", 64'(hit2), 64'd1027);
      expect_ev(1, mk_ev(2'd3, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00), "timeout_ev_a");
      expect_ev(2, mk_ev(2'd3, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00), "timeout_ev_b");
      check("timeout_busy", 64'({a_busy, b_busy}), 64'd0);

      // Reset in the middle of an LED word
      start_frame();
      for (int i = 31; i > 21; i--) send_bit(w16[i]);
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(10);
      check("midreset_outs_a", {a_valid, a_index, a_bright, a_blue, a_green, a_red, a_done, a_len, a_err, a_busy}, 64'd0);
      check("midreset_no_events", 64'(q1.size() + q2.size()), 64'd0);
      start_frame();
      send_word(32'hE310_2030);
      send_word(END_WORD);
      idle(4);
      for (int d = 1; d <= 2; d++) begin
         expect_ev(d, mk_ev(2'd1, 5'd0, 5'd0, 5'd3, 8'h10, 8'h20, 8'h30), "post_reset_led");
         expect_ev(d, mk_ev(2'd2, 5'd0, 5'd1, 5'd0, 8'h00, 8'h00, 8'h00), "post_reset_done");
      end

      check("final_no_extra", 64'(q1.size() + q2.size()), 64'd0);
      check("one_strobe_per_cycle", 64'(multi_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
